// File: rtl/capture_buffer.sv
// Pre/post-trigger capture buffer; readout returns a word 1 cycle after rd_req, with no backpressure (one word per request).
// Optional trigger timestamp via CAPTURE_TIMESTAMP_EN; when undefined, trig_time is tied to 0.
module capture_buffer #(
  parameter int DEPTH_LOG2 = 8,
  parameter int PRE        = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [32:0] data,
  input  logic        start,
  input  logic        trig,
  input  logic        rd_req,
  output logic [32:0] rd_data,
  output logic        rd_valid,
  output logic        rd_last,
  output logic        busy,
  output logic        done,
  output logic [15:0] trig_time
);
  localparam int AW    = DEPTH_LOG2;
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int POST  = DEPTH - PRE;

  localparam logic [AW-1:0] PRE_A   = AW'(PRE);
  localparam logic [AW-1:0] PRE_M1  = AW'(PRE - 1);
  localparam logic [AW-1:0] POST_M1 = AW'(POST - 1);

  typedef enum logic [2:0] {IDLE, FILL, ARMED, POST_TRIG, READ} state_t;

  state_t state, state_d;

  logic [32:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, wr_addr, cnt, rd_cnt;
  logic          wr_en, rd_en, trig_hit;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d  = state;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    trig_hit = 1'b0;
    wr_addr  = wr_ptr;
    unique case (state)
      IDLE: begin
        wr_addr = '0;
        if (start) begin
          wr_en   = 1'b1;
          state_d = (PRE == 1) ? ARMED : FILL;
        end
      end
      FILL: begin
        if (!start) state_d = IDLE;
        else begin
          wr_en = 1'b1;
          if (cnt == PRE_M1) state_d = ARMED;
        end
      end
      ARMED: begin
        if (!start) state_d = IDLE;
        else begin
          wr_en = 1'b1;
          if (trig) begin
            trig_hit = 1'b1;
            state_d  = (POST == 1) ? READ : POST_TRIG;
          end
        end
      end
      POST_TRIG: begin
        if (!start) state_d = IDLE;
        else begin
          wr_en = 1'b1;
          if (cnt == POST_M1) state_d = READ;
        end
      end
      READ: begin
        if (rd_req) begin
          rd_en = 1'b1;
          if (&rd_cnt) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // cnt counts writes in the current phase: fill writes, then trigger-plus-post writes.
  // The read pointer is derived directly at trigger time (oldest retained sample).
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      rd_cnt   <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      rd_last  <= rd_en && (&rd_cnt);
      if (wr_en) wr_ptr <= wr_addr + AW'(1);
      if (state == IDLE) begin
        cnt    <= AW'(1);
        rd_cnt <= '0;
      end else if (trig_hit) begin
        cnt    <= AW'(1);
        rd_ptr <= wr_ptr - PRE_A;
      end else if (rd_en) begin
        rd_ptr <= rd_ptr + AW'(1);
        rd_cnt <= rd_cnt + AW'(1);
      end else begin
        cnt <= cnt + AW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en && !reset) mem[wr_addr] <= data;
  end

  always_ff @(posedge clock) begin
    if (reset)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_ptr];
  end

  assign busy = (state == FILL) || (state == ARMED) || (state == POST_TRIG);
  assign done = (state == READ);

`ifdef CAPTURE_TIMESTAMP_EN
  logic [15:0] ts_cnt, ts_q;

  // The start cycle is cycle 0, so the counter reads k during the k-th cycle after it.
  always_ff @(posedge clock) begin
    if (reset) begin
      ts_cnt <= '0;
      ts_q   <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        ts_cnt <= 16'd1;
        ts_q   <= '0;
      end
    end else begin
      if (busy && ts_cnt != 16'hFFFF) ts_cnt <= ts_cnt + 16'd1;
      if (trig_hit) ts_q <= ts_cnt;
    end
  end

  assign trig_time = ts_q;
`else
  assign trig_time = '0;
`endif

endmodule

// File: tb/tb_capture_buffer.sv
// Scoreboarded bench for capture_buffer with DEPTH_LOG2=4, PRE=4.
module tb_capture_buffer;
  logic        clock = 1'b0;
  logic        reset, start, trig, rd_req;
  logic [32:0] data, rd_data;
  logic        rd_valid, rd_last, busy, done;
  logic [15:0] trig_time;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [32:0] dat;
    logic        last;
    int          c;
  } exp_t;
  exp_t exp_q[$];

  capture_buffer #(.DEPTH_LOG2(4), .PRE(4)) dut (
    .clock(clock), .reset(reset), .data(data), .start(start), .trig(trig),
    .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
    .busy(busy), .done(done), .trig_time(trig_time)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [32:0] pat(input int k);
    pat = {1'b1, 32'(k)} ^ 33'h0_A5A5_0000;
  endfunction

  function automatic logic [15:0] exp_tt(input int t);
`ifdef CAPTURE_TIMESTAMP_EN
    exp_tt = 16'(t);
`else
    exp_tt = 16'(t) & 16'h0000;
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every presented word must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (!reset && rd_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_rd_valid actual_data=%0h required=no_word", rd_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (rd_data !== e.dat || rd_last !== e.last || cyc != e.c + 1) begin
          failures++;
          $display("FAIL rd_word actual=%0h/last%0b/cyc%0d required=%0h/last%0b/cyc%0d",
                   rd_data, rd_last, cyc, e.dat, e.last, e.c + 1);
        end
      end
    end
  end

  task automatic run_capture(input logic [63:0] tmask, input int drop_at, input int max_cyc,
                             input logic exp_done);
    for (int k = 0; k < max_cyc; k++) begin
      data  = pat(k);
      start = (drop_at < 0) || (k < drop_at);
      trig  = tmask[k];
      @(posedge clock); #1;
      if (k == 5) chk("busy_in_capture", busy, 1);
      if (done) break;
    end
    start = 1'b0;
    trig  = 1'b0;
    chk("capture_done", done, exp_done);
  endtask

  task automatic do_reads(input int base, input int n, input int gap);
    for (int j = 0; j < n; j++) begin
      rd_req = 1'b1;
      exp_q.push_back('{dat: pat(base + j), last: (j == 15), c: cyc});
      @(posedge clock); #1;
      rd_req = 1'b0;
      repeat (gap) begin @(posedge clock); #1; end
    end
    rd_req = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic idle_reads(input string name, input int n);
    for (int j = 0; j < n; j++) begin
      rd_req = 1'b1;
      @(posedge clock); #1;
      rd_req = 1'b0;
      chk(name, rd_valid, 0);
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_rd_last"}, rd_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rd_data"}, rd_data, 0);
    chk({tag, "_trig_time"}, trig_time, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b1; trig = 1'b1; rd_req = 1'b1; data = pat(99);
    repeat (2) @(posedge clock);
    #1;
    reset_checks("reset");
    reset = 1'b0; start = 1'b0; trig = 1'b0; rd_req = 1'b0;
    @(posedge clock); #1;

    // Basic capture: trigger at cycle 10.
    run_capture(64'h1 << 10, -1, 40, 1'b1);
    chk("trig_time_10", trig_time, exp_tt(10));
    do_reads(6, 16, 0);
    chk("idle_after_read_done", done, 0);
    idle_reads("rd_req_in_idle", 2);

    // Abort during POST.
    run_capture(64'h1 << 10, 12, 30, 1'b0);
    chk("abort_busy", busy, 0);
    idle_reads("rd_req_after_abort", 3);

    // Early pulses during FILL are ignored.
    run_capture((64'h1 << 1) | (64'h1 << 2) | (64'h1 << 20), -1, 50, 1'b1);
    chk("trig_time_20", trig_time, exp_tt(20));
    do_reads(16, 16, 0);

    // Wrapped buffer, alternating requests, then extra requests.
    run_capture(64'h1 << 30, -1, 60, 1'b1);
    chk("trig_time_30", trig_time, exp_tt(30));
    do_reads(26, 16, 1);
    chk("done_after_alt", done, 0);
    idle_reads("extra_rd_req", 3);

    // Reset in the middle of readout, then a fresh capture.
    run_capture(64'h1 << 10, -1, 40, 1'b1);
    do_reads(6, 5, 0);
    reset = 1'b1; start = 1'b1; rd_req = 1'b1;
    @(posedge clock); #1;
    reset_checks("midread_reset");
    reset = 1'b0; start = 1'b0; rd_req = 1'b0;
    @(posedge clock); #1;
    run_capture(64'h1 << 10, -1, 40, 1'b1);
    chk("trig_time_after_reset", trig_time, exp_tt(10));
    do_reads(6, 16, 0);

    repeat (2) @(posedge clock);
    #1;
    chk("scoreboard_empty", 64'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
